// File: rtl/mor1kx_bus_arbiter_espresso_pkg.sv
// Shared definitions for the espresso two-master bus arbiter:
// state encoding, master IDs and the 2-way arbitration pick.
package mor1kx_bus_arbiter_espresso_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IBUS = 2'd1,
        ST_DBUS = 2'd2
    } arb_state_e;

    localparam logic MASTER_IBUS = 1'b0;
    localparam logic MASTER_DBUS = 1'b1;

    // Fetches are always full-word reads.
    localparam logic [3:0] BSEL_ALL = 4'b1111;

    // Choose between two requesters. With rr_en clear, dbus has fixed
    // priority. With rr_en set, a simultaneous request goes to the master
    // that did not win last time. A lone requester always wins.
    function automatic logic pick_winner(input logic ibus_req,
                                         input logic dbus_req,
                                         input logic last_owner,
                                         input logic rr_en);
        logic winner;
        winner = MASTER_IBUS;
        if (ibus_req && dbus_req) begin
            if (rr_en)
                winner = (last_owner == MASTER_IBUS) ? MASTER_DBUS : MASTER_IBUS;
            else
                winner = MASTER_DBUS;
        end else if (dbus_req) begin
            winner = MASTER_DBUS;
        end
        return winner;
    endfunction

endpackage

// File: rtl/mor1kx_bus_arbiter_espresso.sv
// Two-master (fetch/LSU) arbiter in front of the single external bus bridge.
// One grant covers exactly one bus transaction. Request fields are registered
// at grant time, and the response goes only to the owning master.
// Optional build macro: MOR1KX_BUS_ARB_ROUND_ROBIN_EN makes simultaneous
// requests alternate between the masters. Without it, dbus has fixed
// priority.
module mor1kx_bus_arbiter_espresso
    import mor1kx_bus_arbiter_espresso_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic                            ibus_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] ibus_adr_i,
    output logic                            ibus_ack_o,
    output logic                            ibus_err_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] ibus_dat_o,

    input  logic                            dbus_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] dbus_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] dbus_dat_i,
    input  logic [3:0]                      dbus_bsel_i,
    input  logic                            dbus_we_i,
    output logic                            dbus_ack_o,
    output logic                            dbus_err_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] dbus_dat_o,

    output logic                            bus_req_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] bus_adr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] bus_dat_o,
    output logic [3:0]                      bus_bsel_o,
    output logic                            bus_we_o,
    input  logic                            bus_ack_i,
    input  logic                            bus_err_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] bus_dat_i,

    output logic [1:0]                      arb_grant_o
);

    localparam int W = OPTION_OPERAND_WIDTH;

    arb_state_e     state_q, state_d;
    logic           bus_req_q, bus_req_d;
    logic [W-1:0]   bus_adr_q, bus_adr_d;
    logic [W-1:0]   bus_dat_q, bus_dat_d;
    logic [3:0]     bus_bsel_q, bus_bsel_d;
    logic           bus_we_q, bus_we_d;
    logic           abort_q, abort_d;

    logic           winner;
    logic           owner_req;
    logic           bus_done;
    logic           last_owner;

`ifdef MOR1KX_BUS_ARB_ROUND_ROBIN_EN
    localparam logic RR_EN = 1'b1;
    logic last_owner_q, last_owner_d;

    assign last_owner = last_owner_q;

    // Remember who won the last arbitration. After reset, ibus counts as the
    // last owner, so the first tie goes to dbus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_owner_q <= MASTER_IBUS;
        else
            last_owner_q <= last_owner_d;
    end

    // Update only when a grant is actually issued from IDLE.
    always_comb begin
        last_owner_d = last_owner_q;
        if (state_q == ST_IDLE && (ibus_req_i || dbus_req_i))
            last_owner_d = winner;
    end
`else
    localparam logic RR_EN = 1'b0;
    assign last_owner = MASTER_IBUS;
`endif

    // Arbitration result. It only matters in IDLE.
    assign winner    = pick_winner(ibus_req_i, dbus_req_i, last_owner, RR_EN);

    // The current owner's request line, used to detect an abandoned cycle.
    assign owner_req = (state_q == ST_DBUS) ? dbus_req_i : ibus_req_i;

    // The bus cycle ends on either ack or err.
    assign bus_done  = bus_ack_i | bus_err_i;

    // State and registered bus fields. Reset drops any in-flight cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            bus_req_q  <= 1'b0;
            bus_adr_q  <= '0;
            bus_dat_q  <= '0;
            bus_bsel_q <= 4'b0000;
            bus_we_q   <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bus_req_q  <= bus_req_d;
            bus_adr_q  <= bus_adr_d;
            bus_dat_q  <= bus_dat_d;
            bus_bsel_q <= bus_bsel_d;
            bus_we_q   <= bus_we_d;
            abort_q    <= abort_d;
        end
    end

    // Next state: grant from IDLE, then hold everything until the bus completes.
    always_comb begin
        state_d    = state_q;
        bus_req_d  = bus_req_q;
        bus_adr_d  = bus_adr_q;
        bus_dat_d  = bus_dat_q;
        bus_bsel_d = bus_bsel_q;
        bus_we_d   = bus_we_q;
        abort_d    = abort_q;

        unique case (state_q)
            ST_IDLE: begin
                // A bus ack/err seen here is stray and is ignored.
                abort_d = 1'b0;
                if (ibus_req_i || dbus_req_i) begin
                    bus_req_d = 1'b1;
                    if (winner == MASTER_DBUS) begin
                        state_d    = ST_DBUS;
                        bus_adr_d  = dbus_adr_i;
                        bus_dat_d  = dbus_dat_i;
                        bus_bsel_d = dbus_bsel_i;
                        bus_we_d   = dbus_we_i;
                    end else begin
                        state_d    = ST_IBUS;
                        bus_adr_d  = ibus_adr_i;
                        bus_dat_d  = '0;
                        bus_bsel_d = BSEL_ALL;
                        bus_we_d   = 1'b0;
                    end
                end
            end

            ST_IBUS, ST_DBUS: begin
                if (bus_done) begin
                    state_d   = ST_IDLE;
                    bus_req_d = 1'b0;
                    abort_d   = 1'b0;
                end else if (!owner_req) begin
                    // The owner gave up. Finish the bus cycle anyway, but
                    // swallow its response.
                    abort_d = 1'b1;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
                abort_d   = 1'b0;
            end
        endcase
    end

    // Route the response combinationally to the owner only, unless aborted.
    always_comb begin
        ibus_ack_o = 1'b0;
        ibus_err_o = 1'b0;
        dbus_ack_o = 1'b0;
        dbus_err_o = 1'b0;
        if (!abort_q) begin
            if (state_q == ST_IBUS) begin
                ibus_ack_o = bus_ack_i;
                ibus_err_o = bus_err_i;
            end
            if (state_q == ST_DBUS) begin
                dbus_ack_o = bus_ack_i;
                dbus_err_o = bus_err_i;
            end
        end
    end

    // Read data is broadcast. Only the ack qualifies it.
    assign ibus_dat_o  = bus_dat_i;
    assign dbus_dat_o  = bus_dat_i;

    assign bus_req_o   = bus_req_q;
    assign bus_adr_o   = bus_adr_q;
    assign bus_dat_o   = bus_dat_q;
    assign bus_bsel_o  = bus_bsel_q;
    assign bus_we_o    = bus_we_q;

    assign arb_grant_o = {state_q == ST_DBUS, state_q == ST_IBUS};

endmodule

// File: tb/tb_mor1kx_bus_arbiter_espresso.sv
// Directed bench for mor1kx_bus_arbiter_espresso. Inputs change 1 time unit
// after the rising edge. Outputs are checked a further unit later, so every
// check sits well away from the active edge.
module tb_mor1kx_bus_arbiter_espresso;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         ibus_req_i;
    logic [W-1:0] ibus_adr_i;
    logic         ibus_ack_o, ibus_err_o;
    logic [W-1:0] ibus_dat_o;
    logic         dbus_req_i;
    logic [W-1:0] dbus_adr_i, dbus_dat_i;
    logic [3:0]   dbus_bsel_i;
    logic         dbus_we_i;
    logic         dbus_ack_o, dbus_err_o;
    logic [W-1:0] dbus_dat_o;
    logic         bus_req_o;
    logic [W-1:0] bus_adr_o, bus_dat_o;
    logic [3:0]   bus_bsel_o;
    logic         bus_we_o;
    logic         bus_ack_i, bus_err_i;
    logic [W-1:0] bus_dat_i;
    logic [1:0]   arb_grant_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] exp_grant;

    mor1kx_bus_arbiter_espresso #(.OPTION_OPERAND_WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .ibus_req_i  (ibus_req_i),
        .ibus_adr_i  (ibus_adr_i),
        .ibus_ack_o  (ibus_ack_o),
        .ibus_err_o  (ibus_err_o),
        .ibus_dat_o  (ibus_dat_o),
        .dbus_req_i  (dbus_req_i),
        .dbus_adr_i  (dbus_adr_i),
        .dbus_dat_i  (dbus_dat_i),
        .dbus_bsel_i (dbus_bsel_i),
        .dbus_we_i   (dbus_we_i),
        .dbus_ack_o  (dbus_ack_o),
        .dbus_err_o  (dbus_err_o),
        .dbus_dat_o  (dbus_dat_o),
        .bus_req_o   (bus_req_o),
        .bus_adr_o   (bus_adr_o),
        .bus_dat_o   (bus_dat_o),
        .bus_bsel_o  (bus_bsel_o),
        .bus_we_o    (bus_we_o),
        .bus_ack_i   (bus_ack_i),
        .bus_err_i   (bus_err_i),
        .bus_dat_i   (bus_dat_i),
        .arb_grant_o (arb_grant_o)
    );

    always #5 clk = ~clk;

    // Safety net in case the sequence below ever stalls.
    initial begin
        #20000;
        $display("FAIL timeout: sequence did not finish within 20000 time units");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        ibus_req_i = 1'b1; ibus_adr_i = 32'h0;
        dbus_req_i = 1'b1; dbus_adr_i = 32'h0; dbus_dat_i = 32'h0;
        dbus_bsel_i = 4'hF; dbus_we_i = 1'b0;
        bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_dat_i = 32'h0;

        // Reset held with both requests high.
        repeat (3) tick();
        #1;
        check("rst_bus_req",  {31'b0, bus_req_o}, 32'h0);
        check("rst_bus_adr",  bus_adr_o, 32'h0);
        check("rst_bus_dat",  bus_dat_o, 32'h0);
        check("rst_bus_bsel", {28'b0, bus_bsel_o}, 32'h0);
        check("rst_bus_we",   {31'b0, bus_we_o}, 32'h0);
        check("rst_grant",    {30'b0, arb_grant_o}, 32'h0);

        // A single ibus fetch.
        tick();
        rst = 1'b1;
        dbus_req_i = 1'b0;
        ibus_adr_i = 32'h100;
        tick(); #1;
        check("i_bus_req",  {31'b0, bus_req_o}, 32'h1);
        check("i_bus_adr",  bus_adr_o, 32'h100);
        check("i_bus_bsel", {28'b0, bus_bsel_o}, 32'hF);
        check("i_bus_we",   {31'b0, bus_we_o}, 32'h0);
        check("i_bus_dat",  bus_dat_o, 32'h0);
        check("i_grant",    {30'b0, arb_grant_o}, 32'h1);
        bus_ack_i = 1'b1; bus_dat_i = 32'hDEADBEEF;
        #1;
        check("i_ack",      {31'b0, ibus_ack_o}, 32'h1);
        check("i_dat",      ibus_dat_o, 32'hDEADBEEF);
        check("i_d_ack",    {31'b0, dbus_ack_o}, 32'h0);
        tick();
        bus_ack_i = 1'b0; ibus_req_i = 1'b0;
        #1;
        check("i_done_req",   {31'b0, bus_req_o}, 32'h0);
        check("i_done_grant", {30'b0, arb_grant_o}, 32'h0);

        // Both masters request together. dbus is served first.
        ibus_req_i = 1'b1; ibus_adr_i = 32'h200;
        dbus_req_i = 1'b1; dbus_adr_i = 32'h2002; dbus_dat_i = 32'h0000ABCD;
        dbus_bsel_i = 4'b0011; dbus_we_i = 1'b1;
        tick(); #1;
        check("both_grant_d", {30'b0, arb_grant_o}, 32'h2);
        check("both_adr_d",   bus_adr_o, 32'h2002);
        check("both_dat_d",   bus_dat_o, 32'h0000ABCD);
        check("both_bsel_d",  {28'b0, bus_bsel_o}, 32'h3);
        check("both_we_d",    {31'b0, bus_we_o}, 32'h1);
        bus_ack_i = 1'b1;
        #1;
        check("both_dack",    {31'b0, dbus_ack_o}, 32'h1);
        check("both_iack0",   {31'b0, ibus_ack_o}, 32'h0);
        tick();
        bus_ack_i = 1'b0; dbus_req_i = 1'b0;
        #1;
        check("both_idle",    {30'b0, arb_grant_o}, 32'h0);
        tick(); #1;
        check("both_grant_i", {30'b0, arb_grant_o}, 32'h1);
        check("both_adr_i",   bus_adr_o, 32'h200);
        check("both_bsel_i",  {28'b0, bus_bsel_o}, 32'hF);
        check("both_we_i",    {31'b0, bus_we_o}, 32'h0);
        bus_ack_i = 1'b1;
        #1;
        check("both_iack",    {31'b0, ibus_ack_o}, 32'h1);
        tick();
        bus_ack_i = 1'b0; ibus_req_i = 1'b0;

        // Four transactions with both requests held. The last grant was ibus.
        ibus_req_i = 1'b1; dbus_req_i = 1'b1; dbus_we_i = 1'b0;
        for (int t = 0; t < 4; t++) begin
`ifdef MOR1KX_BUS_ARB_ROUND_ROBIN_EN
            exp_grant = (t % 2 == 0) ? 2'b10 : 2'b01;
`else
            exp_grant = 2'b10;
`endif
            tick(); #1;
            check($sformatf("seq_grant%0d", t), {30'b0, arb_grant_o}, {30'b0, exp_grant});
            bus_ack_i = 1'b1;
            tick();
            bus_ack_i = 1'b0;
        end
        ibus_req_i = 1'b0; dbus_req_i = 1'b0;
        tick();

        // dbus abandons its load. The bus cycle still runs to the ack.
        dbus_req_i = 1'b1; dbus_adr_i = 32'h300; dbus_we_i = 1'b0; dbus_bsel_i = 4'hF;
        tick();              // granted
        tick(); tick();      // two cycles into the grant
        dbus_req_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick(); #1;
            check($sformatf("ab_req%0d", c),  {31'b0, bus_req_o}, 32'h1);
            check($sformatf("ab_dack%0d", c), {31'b0, dbus_ack_o}, 32'h0);
        end
        bus_ack_i = 1'b1;
        #1;
        check("ab_dack_end", {31'b0, dbus_ack_o}, 32'h0);
        check("ab_iack_end", {31'b0, ibus_ack_o}, 32'h0);
        tick();
        bus_ack_i = 1'b0;
        #1;
        check("ab_idle",  {30'b0, arb_grant_o}, 32'h0);
        check("ab_req_0", {31'b0, bus_req_o}, 32'h0);

        // A bus error on a dbus load.
        dbus_req_i = 1'b1; dbus_adr_i = 32'h400;
        tick();
        bus_err_i = 1'b1;
        #1;
        check("err_derr", {31'b0, dbus_err_o}, 32'h1);
        check("err_ierr", {31'b0, ibus_err_o}, 32'h0);
        check("err_dack", {31'b0, dbus_ack_o}, 32'h0);
        tick();
        bus_err_i = 1'b0; dbus_req_i = 1'b0;
        #1;
        check("err_derr_clr", {31'b0, dbus_err_o}, 32'h0);

        // A stray ack while idle reaches no master.
        bus_ack_i = 1'b1;
        #1;
        check("spur_iack", {31'b0, ibus_ack_o}, 32'h0);
        check("spur_dack", {31'b0, dbus_ack_o}, 32'h0);
        tick();
        bus_ack_i = 1'b0;
        #1;
        check("spur_grant", {30'b0, arb_grant_o}, 32'h0);

        // Reset lands during a pending dbus transaction.
        dbus_req_i = 1'b1; dbus_adr_i = 32'h500;
        tick(); #1;
        check("rm_req", {31'b0, bus_req_o}, 32'h1);
        rst = 1'b0;
        #1;
        check("rm_req0",   {31'b0, bus_req_o}, 32'h0);
        check("rm_grant0", {30'b0, arb_grant_o}, 32'h0);
        dbus_req_i = 1'b0;
        tick();
        rst = 1'b1;
        bus_ack_i = 1'b1;
        #1;
        check("rm_dack", {31'b0, dbus_ack_o}, 32'h0);
        tick();
        bus_ack_i = 1'b0;
        #1;
        check("rm_idle", {30'b0, arb_grant_o}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
